// File: rtl/cv32e40p_if_id_pipe_ft_if.sv
// IF/ID pipeline register bundle: aligner-side capture controls in, voted payload and error status out.
// Master drives the fetch-side controls; slave is the pipeline register itself.
interface cv32e40p_if_id_pipe_ft_if #(
    parameter int NUM_REPLICAS = 3,
    parameter int ERR_CNT_W    = 8
);
    logic                    load_i;
    logic                    clear_i;
    logic [31:0]             instr_i;
    logic [31:0]             pc_i;
    logic                    is_compressed_i;
    logic                    illegal_c_i;
    logic                    fetch_failed_i;
    logic                    err_clr_i;

    logic                    instr_valid_o;
    logic [31:0]             instr_rdata_o;
    logic [31:0]             pc_o;
    logic                    is_compressed_o;
    logic                    illegal_c_insn_o;
    logic                    is_fetch_failed_o;
    logic                    err_detect_o;
    logic                    err_multi_o;
    logic [NUM_REPLICAS-1:0] replica_fault_o;
    logic [ERR_CNT_W-1:0]    err_cnt_o;

    modport master (
        output load_i, clear_i, instr_i, pc_i, is_compressed_i, illegal_c_i,
               fetch_failed_i, err_clr_i,
        input  instr_valid_o, instr_rdata_o, pc_o, is_compressed_o, illegal_c_insn_o,
               is_fetch_failed_o, err_detect_o, err_multi_o, replica_fault_o, err_cnt_o
    );

    modport slave (
        input  load_i, clear_i, instr_i, pc_i, is_compressed_i, illegal_c_i,
               fetch_failed_i, err_clr_i,
        output instr_valid_o, instr_rdata_o, pc_o, is_compressed_o, illegal_c_insn_o,
               is_fetch_failed_o, err_detect_o, err_multi_o, replica_fault_o, err_cnt_o
    );
endinterface

// File: rtl/cv32e40p_if_id_pipe_ft.sv
// Fault-tolerant IF/ID register (1 or 3 replicas) with majority vote, scrub and error accounting.
// One-cycle latency like a plain register; outputs are voted combinationally; no backpressure.
module cv32e40p_if_id_pipe_ft #(
    parameter int NUM_REPLICAS = 3,
    parameter int ENABLE_SCRUB = 1,
    parameter int ERR_CNT_W    = 8
) (
    input logic                     clk,
    input logic                     rst_n,
    cv32e40p_if_id_pipe_ft_if.slave pipe
);

    typedef struct packed {
        logic        valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        compressed;
        logic        illegal;
        logic        fetch_failed;
    } payload_t;

    payload_t                rep_q [NUM_REPLICAS];
    payload_t                voted;
    payload_t                wr_dat;
    logic                    wr_en;
    logic [NUM_REPLICAS-1:0] mismatch;
    logic                    err_detect;
    logic                    err_multi;
    logic [NUM_REPLICAS-1:0] fault_q;
    logic [ERR_CNT_W-1:0]    err_cnt_q;

    // Every replica takes the same word; clear and scrub source from the vote so an
    // upset replica is repaired by whichever of them fires first.
    always_comb begin
        wr_en  = 1'b1;
        wr_dat = voted;
        if (pipe.load_i) begin
            wr_dat.valid        = 1'b1;
            wr_dat.instr        = pipe.instr_i;
            wr_dat.pc           = pipe.pc_i;
            wr_dat.compressed   = pipe.is_compressed_i;
            wr_dat.illegal      = pipe.illegal_c_i;
            wr_dat.fetch_failed = 1'b0;
        end else if (pipe.clear_i) begin
            wr_dat.valid        = 1'b0;
            wr_dat.fetch_failed = pipe.fetch_failed_i;
        end else begin
            wr_en = (ENABLE_SCRUB != 0) && err_detect;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REPLICAS; i++) rep_q[i] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_REPLICAS; i++) rep_q[i] <= wr_dat;
        end
    end

    generate
        if (NUM_REPLICAS == 3) begin : g_tmr
            logic err_detect_q;

            assign voted = (rep_q[0] & rep_q[1]) | (rep_q[1] & rep_q[2]) | (rep_q[0] & rep_q[2]);

            always_comb begin
                mismatch = '0;
                for (int i = 0; i < 3; i++) mismatch[i] = (rep_q[i] != voted);
            end

            assign err_detect = |mismatch;
            assign err_multi  = (mismatch[0] & mismatch[1]) | (mismatch[1] & mismatch[2]) |
                                (mismatch[0] & mismatch[2]);

            // Counts rising edges of err_detect so a persistent unscrubbed upset counts once;
            // a clear in the same cycle as a new event drops that event.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    err_detect_q <= 1'b0;
                    err_cnt_q    <= '0;
                    fault_q      <= '0;
                end else begin
                    err_detect_q <= err_detect;
                    if (pipe.err_clr_i) begin
                        err_cnt_q <= '0;
                        fault_q   <= '0;
                    end else begin
                        fault_q <= fault_q | mismatch;
                        if (err_detect && !err_detect_q && (err_cnt_q != '1))
                            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                    end
                end
            end
        end else if (NUM_REPLICAS == 1) begin : g_single
            assign voted      = rep_q[0];
            assign mismatch   = '0;
            assign err_detect = 1'b0;
            assign err_multi  = 1'b0;
            assign fault_q    = '0;
            assign err_cnt_q  = '0;
        end else begin : g_bad_replicas
            $error("cv32e40p_if_id_pipe_ft: NUM_REPLICAS must be 1 or 3");
        end
    endgenerate

    assign pipe.instr_valid_o     = voted.valid;
    assign pipe.instr_rdata_o     = voted.instr;
    assign pipe.pc_o              = voted.pc;
    assign pipe.is_compressed_o   = voted.compressed;
    assign pipe.illegal_c_insn_o  = voted.illegal;
    assign pipe.is_fetch_failed_o = voted.fetch_failed;
    assign pipe.err_detect_o      = err_detect;
    assign pipe.err_multi_o       = err_multi;
    assign pipe.replica_fault_o   = fault_q;
    assign pipe.err_cnt_o         = err_cnt_q;

endmodule

// File: tb/tb_cv32e40p_if_id_pipe_ft.sv
// Bench for cv32e40p_if_id_pipe_ft: four configurations share one stimulus stream and are
// compared every cycle against a per-configuration behavioural model.
module tb_cv32e40p_if_id_pipe_ft;

    logic        clk;
    logic        rst_n;
    logic        load, clear, eclr, cmp, ill, ffl;
    logic [31:0] instr, pc;
    int          n_compared;
    int          n_mismatched;

    // u0: TMR+scrub, u1: TMR no scrub, u2: TMR with 2-bit counter, u3: single replica
    cv32e40p_if_id_pipe_ft_if #(.NUM_REPLICAS(3), .ERR_CNT_W(8)) ifc0 ();
    cv32e40p_if_id_pipe_ft_if #(.NUM_REPLICAS(3), .ERR_CNT_W(8)) ifc1 ();
    cv32e40p_if_id_pipe_ft_if #(.NUM_REPLICAS(3), .ERR_CNT_W(2)) ifc2 ();
    cv32e40p_if_id_pipe_ft_if #(.NUM_REPLICAS(1), .ERR_CNT_W(8)) ifc3 ();

    cv32e40p_if_id_pipe_ft #(.NUM_REPLICAS(3), .ENABLE_SCRUB(1), .ERR_CNT_W(8))
        u0 (.clk(clk), .rst_n(rst_n), .pipe(ifc0));
    cv32e40p_if_id_pipe_ft #(.NUM_REPLICAS(3), .ENABLE_SCRUB(0), .ERR_CNT_W(8))
        u1 (.clk(clk), .rst_n(rst_n), .pipe(ifc1));
    cv32e40p_if_id_pipe_ft #(.NUM_REPLICAS(3), .ENABLE_SCRUB(1), .ERR_CNT_W(2))
        u2 (.clk(clk), .rst_n(rst_n), .pipe(ifc2));
    cv32e40p_if_id_pipe_ft #(.NUM_REPLICAS(1), .ENABLE_SCRUB(1), .ERR_CNT_W(8))
        u3 (.clk(clk), .rst_n(rst_n), .pipe(ifc3));

    logic [69:0] stim;
    assign stim = {load, clear, instr, pc, cmp, ill, ffl, eclr};
    assign {ifc0.load_i, ifc0.clear_i, ifc0.instr_i, ifc0.pc_i, ifc0.is_compressed_i,
            ifc0.illegal_c_i, ifc0.fetch_failed_i, ifc0.err_clr_i} = stim;
    assign {ifc1.load_i, ifc1.clear_i, ifc1.instr_i, ifc1.pc_i, ifc1.is_compressed_i,
            ifc1.illegal_c_i, ifc1.fetch_failed_i, ifc1.err_clr_i} = stim;
    assign {ifc2.load_i, ifc2.clear_i, ifc2.instr_i, ifc2.pc_i, ifc2.is_compressed_i,
            ifc2.illegal_c_i, ifc2.fetch_failed_i, ifc2.err_clr_i} = stim;
    assign {ifc3.load_i, ifc3.clear_i, ifc3.instr_i, ifc3.pc_i, ifc3.is_compressed_i,
            ifc3.illegal_c_i, ifc3.fetch_failed_i, ifc3.err_clr_i} = stim;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: payload word = {valid, instr, pc, compressed, illegal, fetch_failed}
    int          nrep  [4] = '{3, 3, 3, 1};
    int          scrub [4] = '{1, 0, 1, 1};
    int          cmax  [4] = '{255, 255, 3, 255};
    logic [67:0] m_rep [4][3];
    logic        m_detq  [4];
    int          m_cnt   [4];
    logic [2:0]  m_fault [4];

    task automatic check_eq(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [67:0] m_vote(int k);
        logic [67:0] v;
        if (nrep[k] == 1) return m_rep[k][0];
        for (int b = 0; b < 68; b++) begin
            int ones = 0;
            for (int r = 0; r < 3; r++) if (m_rep[k][r][b]) ones++;
            v[b] = (ones >= 2);
        end
        return v;
    endfunction

    function automatic logic [2:0] m_mism(int k);
        logic [2:0]  mm = '0;
        logic [67:0] v  = m_vote(k);
        for (int r = 0; r < nrep[k]; r++) mm[r] = (m_rep[k][r] != v);
        return mm;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < 3; r++) m_rep[k][r] = '0;
            m_detq[k]  = 1'b0;
            m_cnt[k]   = 0;
            m_fault[k] = '0;
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 4; k++) begin
            logic [67:0] v, nv;
            logic [2:0]  mm;
            logic        det, wr;
            v   = m_vote(k);
            mm  = m_mism(k);
            det = |mm;
            wr  = 1'b1;
            nv  = v;
            if (load)                         nv = {1'b1, instr, pc, cmp, ill, 1'b0};
            else if (clear)                   nv = {1'b0, v[66:1], ffl};
            else if (!(scrub[k] != 0 && det)) wr = 1'b0;
            if (wr) for (int r = 0; r < nrep[k]; r++) m_rep[k][r] = nv;
            if (eclr) begin
                m_cnt[k]   = 0;
                m_fault[k] = '0;
            end else begin
                m_fault[k] = m_fault[k] | mm;
                if (det && !m_detq[k] && m_cnt[k] < cmax[k]) m_cnt[k]++;
            end
            m_detq[k] = det;
        end
    endtask

    function automatic logic [67:0] dut_pay(int k);
        case (k)
            0: return {ifc0.instr_valid_o, ifc0.instr_rdata_o, ifc0.pc_o, ifc0.is_compressed_o,
                       ifc0.illegal_c_insn_o, ifc0.is_fetch_failed_o};
            1: return {ifc1.instr_valid_o, ifc1.instr_rdata_o, ifc1.pc_o, ifc1.is_compressed_o,
                       ifc1.illegal_c_insn_o, ifc1.is_fetch_failed_o};
            2: return {ifc2.instr_valid_o, ifc2.instr_rdata_o, ifc2.pc_o, ifc2.is_compressed_o,
                       ifc2.illegal_c_insn_o, ifc2.is_fetch_failed_o};
            default: return {ifc3.instr_valid_o, ifc3.instr_rdata_o, ifc3.pc_o, ifc3.is_compressed_o,
                             ifc3.illegal_c_insn_o, ifc3.is_fetch_failed_o};
        endcase
    endfunction

    // {err_detect, err_multi, replica_fault[2:0], err_cnt[7:0]}
    function automatic logic [12:0] dut_stat(int k);
        case (k)
            0: return {ifc0.err_detect_o, ifc0.err_multi_o, ifc0.replica_fault_o, ifc0.err_cnt_o};
            1: return {ifc1.err_detect_o, ifc1.err_multi_o, ifc1.replica_fault_o, ifc1.err_cnt_o};
            2: return {ifc2.err_detect_o, ifc2.err_multi_o, ifc2.replica_fault_o, 6'b0, ifc2.err_cnt_o};
            default: return {ifc3.err_detect_o, ifc3.err_multi_o, 2'b0, ifc3.replica_fault_o, ifc3.err_cnt_o};
        endcase
    endfunction

    task automatic compare_all();
        for (int k = 0; k < 4; k++) begin
            logic [2:0] mm = m_mism(k);
            check_eq($sformatf("u%0d.payload", k), dut_pay(k), m_vote(k));
            check_eq($sformatf("u%0d.status", k), {55'b0, dut_stat(k)},
                     {55'b0, |mm, ($countones(mm) >= 2), m_fault[k], 8'(m_cnt[k])});
        end
    endtask

    // Fault injection: hierarchical write into a replica flop, mirrored into the model.
    task automatic inject(input int k, input int r, input logic [67:0] mask);
        case (k)
            0:       u0.rep_q[r] <= u0.rep_q[r] ^ mask;
            1:       u1.rep_q[r] <= u1.rep_q[r] ^ mask;
            default: u2.rep_q[r] <= u2.rep_q[r] ^ mask;
        endcase
        m_rep[k][r] = m_rep[k][r] ^ mask;
    endtask

    task automatic step(input logic ld, input logic cl, input logic ec, input logic [31:0] ins,
                        input logic [31:0] pcv, input logic c, input logic il, input logic ff);
        load = ld; clear = cl; eclr = ec; instr = ins; pc = pcv; cmp = c; ill = il; ffl = ff;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic hold();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    localparam logic [67:0] ONE = 68'h1;

    initial begin
        n_compared = 0;
        n_mismatched = 0;
        {load, clear, eclr, cmp, ill, ffl} = '0;
        instr = '0;
        pc = '0;
        rst_n = 1'b1;
        model_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        check_eq("reset.valid", 68'(ifc0.instr_valid_o), 68'h0);
        check_eq("reset.cnt", 68'(ifc0.err_cnt_o), 68'h0);
        rst_n = 1'b1;

        step(1'b1, 1'b0, 1'b0, 32'h00A00093, 32'h80, 1'b0, 1'b0, 1'b0);
        check_eq("load.valid", 68'(ifc0.instr_valid_o), 68'h1);
        check_eq("load.instr", 68'(ifc0.instr_rdata_o), 68'h00A00093);
        check_eq("load.pc", 68'(ifc0.pc_o), 68'h80);
        check_eq("load.det", 68'(ifc0.err_detect_o), 68'h0);

        // Replica 1 instr bit 2 (payload bit 37), with and without scrub
        inject(0, 1, ONE << 37);
        inject(1, 1, ONE << 37);
        #1;
        compare_all();
        check_eq("upset.instr", 68'(ifc0.instr_rdata_o), 68'h00A00093);
        check_eq("upset.det", 68'(ifc0.err_detect_o), 68'h1);
        hold();
        check_eq("scrub.det", 68'(ifc0.err_detect_o), 68'h0);
        check_eq("scrub.cnt", 68'(ifc0.err_cnt_o), 68'h1);
        check_eq("scrub.fault", 68'(ifc0.replica_fault_o), 68'b010);
        repeat (9) hold();
        check_eq("noscrub.det", 68'(ifc1.err_detect_o), 68'h1);
        check_eq("noscrub.cnt", 68'(ifc1.err_cnt_o), 68'h1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("repair.valid", 68'(ifc1.instr_valid_o), 68'h0);
        check_eq("repair.det", 68'(ifc1.err_detect_o), 68'h0);

        // Two replicas upset at once: pc bit 0 in r0, instr bit 5 in r2
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h00A00093, 32'h80, 1'b0, 1'b0, 1'b0);
        inject(0, 0, ONE << 3);
        inject(0, 2, ONE << 40);
        #1;
        compare_all();
        check_eq("multi.flag", 68'(ifc0.err_multi_o), 68'h1);
        check_eq("multi.pc", 68'(ifc0.pc_o), 68'h80);
        hold();
        check_eq("multi.cnt", 68'(ifc0.err_cnt_o), 68'h1);
        check_eq("multi.fault", 68'(ifc0.replica_fault_o), 68'b101);

        step(1'b1, 1'b1, 1'b0, 32'h4501, 32'h100, 1'b1, 1'b0, 1'b1);
        check_eq("ldclr.valid", 68'(ifc0.instr_valid_o), 68'h1);
        check_eq("ldclr.comp", 68'(ifc0.is_compressed_o), 68'h1);
        check_eq("ldclr.ff", 68'(ifc0.is_fetch_failed_o), 68'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
        check_eq("clrff.valid", 68'(ifc3.instr_valid_o), 68'h0);
        check_eq("clrff.ff", 68'(ifc3.is_fetch_failed_o), 68'h1);

        // Five separate upsets on the 2-bit counter instance
        for (int i = 0; i < 5; i++) begin
            inject(2, i % 3, ONE << (35 + i));
            hold();
            hold();
        end
        check_eq("sat.cnt", 68'(ifc2.err_cnt_o), 68'h3);
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("errclr.cnt", 68'(ifc2.err_cnt_o), 68'h0);
        check_eq("errclr.fault", 68'(ifc2.replica_fault_o), 68'h0);

        // Asynchronous reset in the middle of a hold cycle
        step(1'b1, 1'b0, 1'b0, 32'hDEADBEEF, 32'h44, 1'b1, 1'b1, 1'b0);
        inject(1, 0, ONE << 10);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check_eq("arst.pc", 68'(ifc0.pc_o), 68'h0);
        check_eq("arst.det", 68'(ifc1.err_detect_o), 68'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic with occasional single/double-bit upsets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(5) == 0) begin
                int k = $urandom_range(2);
                inject(k, $urandom_range(2), ONE << $urandom_range(67));
                if ($urandom_range(3) == 0) inject(k, $urandom_range(2), ONE << $urandom_range(67));
                #1;
                compare_all();
            end
            step($urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(15) == 0,
                 $urandom, $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
